// File: rtl/mash_1_1_modulator.sv
// Second-order MASH 1-1 delta-sigma modulator fed by an AXI-Stream sample source.
// Optional LFSR dither on the stage-1 carry-in: define MASH_1_1_MODULATOR_DITHER_EN.
module mash_1_1_modulator #(
    parameter int WIDTH    = 16,
    parameter int OSR_LOG2 = 4
) (
    input  logic             aclk,
    input  logic             arst_n,
    input  logic [WIDTH-1:0] s_axis_data_tdata,
    input  logic             s_axis_data_tvalid,
    output logic             s_axis_data_tready,
    output logic [1:0]       dac_code,
    output logic             dac_valid,
    output logic             underrun
);
    localparam logic [OSR_LOG2-1:0] CNT_ONE = OSR_LOG2'(1);

    logic [OSR_LOG2-1:0] cnt_q;
    logic [WIDTH-1:0]    pend_q, active_q, acc1_q, acc2_q;
    logic                pend_v_q, started_q, c2d_q;
    logic [1:0]          dac_code_q;
    logic                dac_valid_q, underrun_q;

    logic [WIDTH-1:0]    pend_d, active_d;
    logic                pend_v_d, started_d, underrun_d;
    logic                boundary, hs, cin;
    logic [WIDTH:0]      s1, s2;
    logic                c1, c2;
    logic [1:0]          code_d;

    assign boundary           = &cnt_q;
    assign s_axis_data_tready = ~pend_v_q | boundary;
    assign hs                 = s_axis_data_tvalid & s_axis_data_tready;

`ifdef MASH_1_1_MODULATOR_DITHER_EN
    logic [15:0] lfsr_q;
    logic        lfsr_fb;
    assign lfsr_fb = lfsr_q[15] ^ lfsr_q[14] ^ lfsr_q[12] ^ lfsr_q[3];
    assign cin     = lfsr_q[0];

    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) lfsr_q <= 16'hACE1;
        else         lfsr_q <= {lfsr_q[14:0], lfsr_fb};
    end
`else
    assign cin = 1'b0;
`endif

    // Frame-boundary hand-off: a handshake on the boundary edge refills pend as it drains.
    always_comb begin
        pend_d     = pend_q;
        pend_v_d   = pend_v_q;
        active_d   = active_q;
        started_d  = started_q;
        underrun_d = underrun_q;
        if (boundary) begin
            if (pend_v_q) begin
                active_d  = pend_q;
                started_d = 1'b1;
                pend_v_d  = 1'b0;
            end else if (started_q) begin
                underrun_d = 1'b1;
            end
        end
        if (hs) begin
            pend_d   = s_axis_data_tdata;
            pend_v_d = 1'b1;
        end
    end

    assign s1     = {1'b0, acc1_q} + {1'b0, active_q} + {{WIDTH{1'b0}}, cin};
    assign c1     = s1[WIDTH];
    assign s2     = {1'b0, acc2_q} + {1'b0, s1[WIDTH-1:0]};
    assign c2     = s2[WIDTH];
    // y+1 lies in 0..3, so modulo-4 arithmetic is exact.
    assign code_d = 2'd1 + {1'b0, c1} + {1'b0, c2} - {1'b0, c2d_q};

    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            cnt_q       <= '0;
            pend_q      <= '0;
            pend_v_q    <= 1'b0;
            active_q    <= '0;
            started_q   <= 1'b0;
            acc1_q      <= '0;
            acc2_q      <= '0;
            c2d_q       <= 1'b0;
            dac_code_q  <= 2'd1;
            dac_valid_q <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            cnt_q       <= cnt_q + CNT_ONE;
            pend_q      <= pend_d;
            pend_v_q    <= pend_v_d;
            active_q    <= active_d;
            started_q   <= started_d;
            acc1_q      <= s1[WIDTH-1:0];
            acc2_q      <= s2[WIDTH-1:0];
            c2d_q       <= c2;
            dac_code_q  <= code_d;
            dac_valid_q <= started_q;
            underrun_q  <= underrun_d;
        end
    end

    assign dac_code  = dac_code_q;
    assign dac_valid = dac_valid_q;
    assign underrun  = underrun_q;
endmodule
